// File: rtl/scan_mux_pkg.sv
// scan_mux_pkg: FSM state and mode encodings shared by scan_mux.
package scan_mux_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;
    typedef enum logic {MODE_MANUAL, MODE_SCAN} mode_t;
endpackage

// File: rtl/scan_next_ch.sv
// scan_next_ch: circular search for the lowest enabled channel at or above cur (SCAN_MASK_EN only).
`ifdef SCAN_MASK_EN
module scan_next_ch #(
    parameter int N_CH = 64,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic [SEL_W-1:0] cur,
    input  logic [N_CH-1:0]  mask,
    output logic [SEL_W-1:0] next,
    output logic             last,
    output logic             none
);
    logic [SEL_W-1:0] up, lo, hi;
    logic up_hit, hi_hit;
    always_comb begin
        up = '0;
        lo = '0;
        hi = '0;
        up_hit = 1'b0;
        hi_hit = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lo = SEL_W'(i);
                if (SEL_W'(i) >= cur) begin
                    up = SEL_W'(i);
                    up_hit = 1'b1;
                end
                if (!hi_hit) begin
                    hi = SEL_W'(i);
                    hi_hit = 1'b1;
                end
            end
        end
        next = up_hit ? up : lo;
        last = next == hi;
        none = ~|mask;
    end
endmodule
`endif

// File: rtl/scan_mux.sv
// scan_mux: registered N_CH:1 mux with valid/ready output and a MANUAL/SCAN channel sequencer.
// Optional feature SCAN_MASK_EN adds ch_mask so SCAN skips disabled channels.
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int N_CH  = 64,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH*WIDTH-1:0] in,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel_in,
`ifdef SCAN_MASK_EN
    input  logic [N_CH-1:0]       ch_mask,
`endif
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  sel_err
);
    state_t state, state_nx;
    logic [SEL_W-1:0] cnt, scan_ch, cap_ch;
    logic scan_last, scan_none, scan, man_err, hs, take;
`ifdef SCAN_MASK_EN
    scan_next_ch #(.N_CH(N_CH)) u_next (
        .cur (cnt),
        .mask(ch_mask),
        .next(scan_ch),
        .last(scan_last),
        .none(scan_none)
    );
`else
    assign scan_ch = cnt;
    assign scan_last = cnt == SEL_W'(N_CH - 1);
    assign scan_none = 1'b0;
`endif
    // cnt points at the channel the next SCAN capture will take
    always_comb begin
        scan = mode_t'(mode) == MODE_SCAN;
        man_err = {1'b0, sel_in} >= (SEL_W + 1)'(N_CH);
        cap_ch = scan ? scan_ch : sel_in;
        hs = out_valid & out_ready;
        take = en & ((state == LOAD) | ((state == HOLD) & hs)) & !(scan & scan_none);
        state_nx = state == IDLE ? (en ? LOAD : IDLE)
                 : state == LOAD ? (take ? HOLD : en ? LOAD : IDLE)
                 : (!hs || take) ? HOLD : en ? LOAD : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            out_data <= '0;
            out_ch <= '0;
            out_valid <= 1'b0;
            out_last <= 1'b0;
            sel_err <= 1'b0;
        end else begin
            state <= state_nx;
            out_valid <= take | (out_valid & !hs);
            if (take) begin
                out_data <= (scan | !man_err) ? in[cap_ch*WIDTH +: WIDTH] : '0;
                out_ch <= cap_ch;
                out_last <= scan & scan_last;
                sel_err <= !scan & man_err;
            end
            if (take & scan)
                cnt <= scan_ch == SEL_W'(N_CH - 1) ? '0 : scan_ch + 1'b1;
        end
    end
endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: table/scoreboard bench for scan_mux (64- and 5-channel instances).
module tb_scan_mux;
    typedef struct packed {logic d; logic [5:0] ch; logic l; logic e;} exp_t;
    typedef struct {logic [63:0] in; logic [5:0] sel; exp_t x;} vec_t;
    localparam logic [63:0] PAT = 64'hAAAA_AAAA_AAAA_AAAA;

    logic clk = 1'b0, rst_n = 1'b1;
    logic [63:0] din;
    logic en, mode, out_ready;
    logic [5:0] sel, out_ch;
    logic [0:0] out_data;
    logic out_valid, out_last, sel_err;
    logic [4:0] din5;
    logic en5, mode5, rdy5, ov5, ol5, se5;
    logic [2:0] sel5, och5;
    logic [0:0] od5;
`ifdef SCAN_MASK_EN
    logic [63:0] mask = '1;
    logic [4:0] mask5 = '1;
`endif

    exp_t q[$];
    vec_t tbl[128];
    logic [5:0] nxt;
    int n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    scan_mux #(.WIDTH(1), .N_CH(64)) u64 (
        .clk(clk), .rst_n(rst_n), .in(din), .en(en), .mode(mode), .sel_in(sel),
`ifdef SCAN_MASK_EN
        .ch_mask(mask),
`endif
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .sel_err(sel_err)
    );

    scan_mux #(.WIDTH(1), .N_CH(5)) u5 (
        .clk(clk), .rst_n(rst_n), .in(din5), .en(en5), .mode(mode5), .sel_in(sel5),
`ifdef SCAN_MASK_EN
        .ch_mask(mask5),
`endif
        .out_data(od5), .out_ch(och5), .out_valid(ov5),
        .out_ready(rdy5), .out_last(ol5), .sel_err(se5)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    // drive one cycle at the falling edge; compare the beat about to be accepted, then queue the new capture
    task automatic beat(input logic [63:0] i, input logic [5:0] s, input logic m,
                        input logic e, input logic r, input logic push, input exp_t x);
        exp_t f;
        @(negedge clk);
        din = i; sel = s; mode = m; en = e; out_ready = r;
        if (out_valid && out_ready) begin
            if (q.size() == 0) check("spurious beat", q.size(), 1);
            else begin
                f = q.pop_front();
                check("beat {data,ch,last,err}", {out_data, out_ch, out_last, sel_err}, f);
            end
        end
        if (push) q.push_back(x);
    endtask

    task automatic prime(input logic [63:0] i, input logic [5:0] s, input logic m, input exp_t x);
        logic ok;
        ok = 1'b0;
        beat(i, s, m, 1'b1, 1'b0, 1'b1, x);
        for (int c = 0; c < 8 && !ok; c++) begin
            beat(i, s, m, 1'b1, 1'b0, 1'b0, x);
            ok = out_valid;
        end
        check("prime valid", ok, 1);
    endtask

    task automatic sbeat(input logic [63:0] i, input logic r);
        exp_t x;
        x = {i[nxt], nxt, nxt == 6'd63, 1'b0};
        beat(i, 6'd0, 1'b1, 1'b1, r, r, x);
        if (r) nxt = nxt + 1'b1;
    endtask

    task automatic sprime(input logic [63:0] i);
        exp_t x;
        x = {i[nxt], nxt, nxt == 6'd63, 1'b0};
        prime(i, 6'd0, 1'b1, x);
        nxt = nxt + 1'b1;
    endtask

    task automatic drain();
        exp_t z;
        z = '0;
        beat(din, sel, mode, 1'b0, 1'b1, 1'b0, z);
        beat(din, sel, mode, 1'b0, 1'b1, 1'b0, z);
        check("drained valid", out_valid, 0);
        check("queue empty", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [2:0] m5 [4];
        logic [5:0] mseq [5];
        logic [2:0] c5;
        en = 0; mode = 0; out_ready = 0; sel = 0; din = 0;
        en5 = 0; mode5 = 0; rdy5 = 0; sel5 = 0; din5 = 0;
        nxt = 0;
        #2 rst_n = 1'b0;
        #1 check("reset u64", {out_data, out_ch, out_valid, out_last, sel_err}, 0);
        check("reset u5", {od5, och5, ov5, ol5, se5}, 0);
        @(negedge clk) rst_n = 1'b1;

        // MANUAL walking one then walking zero
        for (int k = 0; k < 128; k++) begin
            tbl[k].in = k < 64 ? 64'h1 << k : ~(64'h1 << (k - 64));
            tbl[k].sel = 6'(k);
            tbl[k].x = {k < 64, 6'(k), 1'b0, 1'b0};
        end
        prime(tbl[0].in, tbl[0].sel, 1'b0, tbl[0].x);
        for (int k = 1; k < 128; k++)
            beat(tbl[k].in, tbl[k].sel, 1'b0, 1'b1, 1'b1, 1'b1, tbl[k].x);
        drain();

        // SCAN full sweep with wrap
        sprime(PAT);
        for (int k = 0; k < 64; k++) sbeat(PAT, 1'b1);
        drain();

        // backpressure at ch 7 while in toggles
        sprime(PAT);
        while (nxt != 6'd8) sbeat(PAT, 1'b1);
        for (int c = 0; c < 5; c++) begin
            beat(c % 2 ? PAT : ~PAT, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
            check("stall ch", out_ch, 7);
            check("stall data", out_data, 1);
        end
        sbeat(~PAT, 1'b1);
        sbeat(~PAT, 1'b1);
        drain();

        // async reset mid-HOLD, SCAN restarts at ch 0
        sprime(PAT);
        sbeat(PAT, 1'b1);
        sbeat(PAT, 1'b1);
        sbeat(PAT, 1'b0);
        #2 rst_n = 1'b0;
        en = 1'b0;
        #1 check("async reset", {out_valid, out_ch, out_data, out_last}, 0);
        q.delete();
        nxt = 0;
        @(negedge clk) rst_n = 1'b1;
        sprime(PAT);
        sbeat(PAT, 1'b1);
        sbeat(PAT, 1'b1);
        drain();

        // N_CH=5: out-of-range select, then SCAN wrap at 4
        din5 = 5'b10110; mode5 = 0; rdy5 = 1; sel5 = 3'd6; en5 = 1;
        for (int c = 0; c < 8 && !ov5; c++) @(negedge clk);
        check("u5 valid", ov5, 1);
        m5 = '{3'd6, 3'd4, 3'd5, 3'd0};
        for (int k = 0; k < 4; k++) begin
            sel5 = m5[k];
            @(negedge clk);
            check("u5 manual {data,ch,err}", {od5, och5, se5},
                  {m5[k] < 3'd5 ? din5[m5[k]] : 1'b0, m5[k], m5[k] >= 3'd5});
        end
        mode5 = 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            c5 = 3'(k % 5);
            check("u5 scan {data,ch,last,err}", {od5, och5, ol5, se5},
                  {din5[c5], c5, c5 == 3'd4, 1'b0});
        end
        en5 = 0;
        @(negedge clk);
        @(negedge clk);
        check("u5 idle", ov5, 0);

`ifdef SCAN_MASK_EN
        en = 0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        mask = 64'h8000_0000_0000_0011;
        mseq = '{6'd0, 6'd4, 6'd63, 6'd0, 6'd4};
        prime(PAT, 6'd0, 1'b1, {PAT[mseq[0]], mseq[0], mseq[0] == 6'd63, 1'b0});
        for (int k = 1; k < 5; k++)
            beat(PAT, 6'd0, 1'b1, 1'b1, 1'b1, 1'b1, {PAT[mseq[k]], mseq[k], mseq[k] == 6'd63, 1'b0});
        drain();
        mask = '0;
        for (int c = 0; c < 6; c++) begin
            beat(PAT, 6'd0, 1'b1, 1'b1, 1'b1, 1'b0, '0);
            check("mask zero valid", out_valid, 0);
        end
        en = 0;
        mask = '1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
